dec_job_scheduler: RTL and testbench

DEC_JOB_SCHEDULER -- requirements
Module: dec_job_scheduler

---
 rtl/dec_job_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dec_job_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_job_scheduler.sv
// rtl/dec_job_scheduler.sv - round-robin job arbiter feeding one decompressor with watchdog and completion queue
module dec_job_scheduler #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int NUM_SLOTS          = 4,
    parameter int SLOT_W             = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_SLOTS-1:0]                    job_valid,
    output logic [NUM_SLOTS-1:0]                    job_ready,
    input  logic [NUM_SLOTS*C_M_AXI_ADDR_WIDTH-1:0] job_src_addr,
    input  logic [NUM_SLOTS*C_M_AXI_ADDR_WIDTH-1:0] job_des_addr,
    input  logic [NUM_SLOTS*32-1:0]                 job_comp_len,
    input  logic [NUM_SLOTS*32-1:0]                 job_decomp_len,
    output logic                                    dec_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           dec_src_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           dec_des_addr,
    output logic [31:0]                             dec_comp_len,
    output logic [31:0]                             dec_decomp_len,
    input  logic                                    dec_done,
    input  logic                                    dec_idle,
    input  logic [31:0]                             timeout_cycles,
    output logic                                    cmpl_valid,
    output logic [SLOT_W-1:0]                       cmpl_slot,
    output logic [1:0]                              cmpl_status,
    input  logic                                    cmpl_ready,
    output logic                                    busy
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CMPL} state_t;

    state_t              state_q;
    logic [AW-1:0]       dec_src_q;
    logic [AW-1:0]       dec_des_q;
    logic [31:0]         dec_comp_q;
    logic [31:0]         dec_decomp_q;
    logic [SLOT_W-1:0]   cur_slot_q;
    logic [SLOT_W-1:0]   last_grant_q;
    logic                cmpl_valid_q;
    logic [SLOT_W-1:0]   cmpl_slot_q;
    logic [1:0]          cmpl_status_q;
    logic [31:0]         wait_cnt_q;
    logic                done_q;

    logic [AW-1:0]       src_arr    [NUM_SLOTS];
    logic [AW-1:0]       des_arr    [NUM_SLOTS];
    logic [31:0]         comp_arr   [NUM_SLOTS];
    logic [31:0]         decomp_arr [NUM_SLOTS];

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_unpack
            assign src_arr[k]    = job_src_addr[k*AW +: AW];
            assign des_arr[k]    = job_des_addr[k*AW +: AW];
            assign comp_arr[k]   = job_comp_len[k*32 +: 32];
            assign decomp_arr[k] = job_decomp_len[k*32 +: 32];
        end
    endgenerate

    // Search starts one past the last served slot so every requester gets a turn.
    logic              grant_vld;
    logic [SLOT_W-1:0] grant_idx;
    logic [SLOT_W-1:0] cand;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            cand = SLOT_W'((int'(last_grant_q) + i) % NUM_SLOTS);
            if (!grant_vld && job_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic zero_len;
    logic done_edge;
    logic timeout_hit;

    assign zero_len    = (comp_arr[grant_idx] == 32'd0) || (decomp_arr[grant_idx] == 32'd0);
    assign done_edge   = dec_done && !done_q;
    assign timeout_hit = (timeout_cycles != 32'd0) && (wait_cnt_q == timeout_cycles - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dec_src_q     <= '0;
            dec_des_q     <= '0;
            dec_comp_q    <= '0;
            dec_decomp_q  <= '0;
            cur_slot_q    <= '0;
            last_grant_q  <= SLOT_W'(NUM_SLOTS - 1);
            cmpl_valid_q  <= 1'b0;
            cmpl_slot_q   <= '0;
            cmpl_status_q <= 2'd0;
            wait_cnt_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= dec_done;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        cur_slot_q   <= grant_idx;
                        dec_src_q    <= src_arr[grant_idx];
                        dec_des_q    <= des_arr[grant_idx];
                        dec_comp_q   <= comp_arr[grant_idx];
                        dec_decomp_q <= decomp_arr[grant_idx];
                        if (zero_len) begin
                            state_q       <= S_CMPL;
                            cmpl_valid_q  <= 1'b1;
                            cmpl_slot_q   <= grant_idx;
                            cmpl_status_q <= 2'd2;
                        end else begin
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (dec_idle) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 32'd1;
                    // A done edge landing on the watchdog's last cycle still counts as success.
                    if (done_edge || timeout_hit) begin
                        state_q       <= S_CMPL;
                        cmpl_valid_q  <= 1'b1;
                        cmpl_slot_q   <= cur_slot_q;
                        cmpl_status_q <= done_edge ? 2'd0 : 2'd1;
                    end
                end
                S_CMPL: begin
                    if (cmpl_ready) begin
                        cmpl_valid_q <= 1'b0;
                        last_grant_q <= cur_slot_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign job_ready      = (state_q == S_IDLE && grant_vld) ? (NUM_SLOTS'(1) << grant_idx) : '0;
    assign dec_start      = (state_q == S_START) && dec_idle;
    assign busy           = (state_q != S_IDLE);
    assign dec_src_addr   = dec_src_q;
    assign dec_des_addr   = dec_des_q;
    assign dec_comp_len   = dec_comp_q;
    assign dec_decomp_len = dec_decomp_q;
    assign cmpl_valid     = cmpl_valid_q;
    assign cmpl_slot      = cmpl_slot_q;
    assign cmpl_status    = cmpl_status_q;

endmodule

// File: tb/tb_dec_job_scheduler.sv
// tb/tb_dec_job_scheduler.sv - lockstep bench for dec_job_scheduler with directed and randomized jobs
module tb_dec_job_scheduler;

    localparam int AW = 64;
    localparam int NS = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     job_valid;
    logic [NS-1:0]     job_ready;
    logic [NS*AW-1:0]  job_src_addr;
    logic [NS*AW-1:0]  job_des_addr;
    logic [NS*32-1:0]  job_comp_len;
    logic [NS*32-1:0]  job_decomp_len;
    logic              dec_start;
    logic [AW-1:0]     dec_src_addr;
    logic [AW-1:0]     dec_des_addr;
    logic [31:0]       dec_comp_len;
    logic [31:0]       dec_decomp_len;
    logic              dec_done;
    logic              dec_idle;
    logic [31:0]       timeout_cycles;
    logic              cmpl_valid;
    logic [1:0]        cmpl_slot;
    logic [1:0]        cmpl_status;
    logic              cmpl_ready;
    logic              busy;

    dec_job_scheduler #(.C_M_AXI_ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_src_addr(job_src_addr), .job_des_addr(job_des_addr),
        .job_comp_len(job_comp_len), .job_decomp_len(job_decomp_len),
        .dec_start(dec_start), .dec_src_addr(dec_src_addr), .dec_des_addr(dec_des_addr),
        .dec_comp_len(dec_comp_len), .dec_decomp_len(dec_decomp_len),
        .dec_done(dec_done), .dec_idle(dec_idle), .timeout_cycles(timeout_cycles),
        .cmpl_valid(cmpl_valid), .cmpl_slot(cmpl_slot), .cmpl_status(cmpl_status),
        .cmpl_ready(cmpl_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int last_g;
    logic [63:0] src_m [NS];
    logic [63:0] dst_m [NS];
    logic [31:0] cl_m  [NS];
    logic [31:0] dl_m  [NS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_desc();
        for (int i = 0; i < NS; i++) begin
            job_src_addr[i*AW +: AW]   = src_m[i];
            job_des_addr[i*AW +: AW]   = dst_m[i];
            job_comp_len[i*32 +: 32]   = cl_m[i];
            job_decomp_len[i*32 +: 32] = dl_m[i];
        end
    endtask

    task automatic load_desc(input bit allow_zero);
        for (int i = 0; i < NS; i++) begin
            src_m[i] = {$urandom, $urandom};
            dst_m[i] = {$urandom, $urandom};
            cl_m[i]  = $urandom_range(1, 1 << 20);
            dl_m[i]  = $urandom_range(1, 1 << 22);
            if (allow_zero && $urandom_range(0, 5) == 0) cl_m[i] = 32'd0;
            if (allow_zero && $urandom_range(0, 5) == 0) dl_m[i] = 32'd0;
        end
        pack_desc();
    endtask

    // Reference arbiter: first requesting slot after the last one served, wrapping.
    function automatic int pick(input logic [NS-1:0] m);
        for (int i = 1; i <= NS; i++) begin
            if (m[(last_g + i) % NS]) return (last_g + i) % NS;
        end
        return 0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_job_ready"}, 64'(job_ready), 64'd0);
        chk({tag, "_dec_start"}, 64'(dec_start), 64'd0);
        chk({tag, "_dec_src"}, dec_src_addr, 64'd0);
        chk({tag, "_dec_des"}, dec_des_addr, 64'd0);
        chk({tag, "_dec_comp"}, 64'(dec_comp_len), 64'd0);
        chk({tag, "_dec_decomp"}, 64'(dec_decomp_len), 64'd0);
        chk({tag, "_cmpl_valid"}, 64'(cmpl_valid), 64'd0);
        chk({tag, "_cmpl_slot"}, 64'(cmpl_slot), 64'd0);
        chk({tag, "_cmpl_status"}, 64'(cmpl_status), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One job, stepped cycle by cycle. done_at/tmo are counted in WAIT cycles (first WAIT cycle = 1).
    task automatic do_job(input logic [NS-1:0] mask, input int idle_dly, input int done_at,
                          input bit pre_high, input int tmo, input int rdy_dly, output int g);
        int   end_w;
        logic [1:0] st;
        job_valid      = mask;
        timeout_cycles = tmo;
        dec_idle       = (idle_dly == 0);
        dec_done       = pre_high;
        cmpl_ready     = 1'b0;
        #1;
        g = pick(mask);
        chk("grant_one_hot", 64'(job_ready), 64'(1) << g);
        chk("idle_not_busy", 64'(busy), 64'd0);
        @(negedge clk);
        job_valid = mask & ~(NS'(1) << g);
        #1;
        chk("latched_src", dec_src_addr, src_m[g]);
        chk("latched_des", dec_des_addr, dst_m[g]);
        chk("latched_comp", 64'(dec_comp_len), 64'(cl_m[g]));
        chk("latched_decomp", 64'(dec_decomp_len), 64'(dl_m[g]));
        chk("busy_after_grant", 64'(busy), 64'd1);
        chk("ready_one_cycle", 64'(job_ready), 64'd0);
        if (cl_m[g] == 32'd0 || dl_m[g] == 32'd0) begin
            st = 2'd2;
            chk("zero_len_no_start", 64'(dec_start), 64'd0);
        end else begin
            for (int c = 0; c <= idle_dly; c++) begin
                if (c > 0) @(negedge clk);
                dec_idle = (c == idle_dly);
                #1;
                chk("start_gated_by_idle", 64'(dec_start), 64'(c == idle_dly));
            end
            end_w = (tmo != 0 && tmo < done_at) ? tmo : done_at;
            st    = (end_w == done_at) ? 2'd0 : 2'd1;
            for (int w = 1; w <= end_w; w++) begin
                @(negedge clk);
                dec_idle = 1'($urandom_range(0, 1));
                dec_done = (w >= done_at) || (pre_high && w < 2);
                #1;
                chk("wait_no_cmpl", 64'(cmpl_valid), 64'd0);
                chk("wait_no_start", 64'(dec_start), 64'd0);
            end
            @(negedge clk);
            dec_done = 1'b0;
            #1;
        end
        chk("cmpl_valid", 64'(cmpl_valid), 64'd1);
        chk("cmpl_slot", 64'(cmpl_slot), 64'(g));
        chk("cmpl_status", 64'(cmpl_status), 64'(st));
        for (int r = 0; r < rdy_dly; r++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", 64'(cmpl_valid), 64'd1);
            chk("stall_slot", 64'(cmpl_slot), 64'(g));
            chk("stall_status", 64'(cmpl_status), 64'(st));
            chk("stall_no_grant", 64'(job_ready), 64'd0);
        end
        cmpl_ready = 1'b1;
        #1;
        chk("no_grant_in_cmpl", 64'(job_ready), 64'd0);
        @(negedge clk);
        cmpl_ready = 1'b0;
        #1;
        chk("cmpl_cleared", 64'(cmpl_valid), 64'd0);
        last_g = g;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gg;
        int pre, dat;
        rst_n = 1'b0;
        job_valid = '0; dec_done = 1'b0; dec_idle = 1'b1;
        timeout_cycles = '0; cmpl_ready = 1'b0;
        job_src_addr = '0; job_des_addr = '0; job_comp_len = '0; job_decomp_len = '0;
        last_g = NS - 1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All slots continuously valid: strict rotation from slot 0.
        load_desc(1'b0);
        for (int k = 0; k < 5; k++) begin
            do_job(4'hF, 0, 3, 1'b0, 0, 0, gg);
            chk("rr_order", 64'(gg), 64'(k % NS));
        end

        // Slot 2 only, 100/400 byte job, done 50 cycles after start.
        load_desc(1'b0);
        cl_m[2] = 32'd100;
        dl_m[2] = 32'd400;
        pack_desc();
        do_job(4'b0100, 0, 50, 1'b0, 0, 1, gg);
        chk("slot2_grant", 64'(gg), 64'd2);

        // Watchdog at 10 WAIT cycles, then watchdog disabled.
        do_job(4'b0001, 0, 1000, 1'b0, 10, 0, gg);
        do_job(4'b1000, 2, 120, 1'b0, 0, 0, gg);

        // Zero-length job on slot 1.
        load_desc(1'b0);
        cl_m[1] = 32'd0;
        pack_desc();
        do_job(4'b0010, 0, 5, 1'b0, 0, 0, gg);

        // Decompressor busy for 5 cycles, done level already high at WAIT entry.
        load_desc(1'b0);
        do_job(4'b0100, 5, 8, 1'b1, 0, 0, gg);

        // Completion stall of 8 cycles, then reset during the next job's WAIT.
        do_job(4'b0010, 0, 4, 1'b0, 0, 8, gg);
        job_valid = 4'b1000;
        dec_idle = 1'b1;
        dec_done = 1'b0;
        timeout_cycles = '0;
        #1;
        chk("pre_reset_grant", 64'(job_ready), 64'(1) << pick(4'b1000));
        @(negedge clk);
        job_valid = 4'b0000;
        #1;
        chk("pre_reset_start", 64'(dec_start), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        #1;
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        last_g = NS - 1;
        @(negedge clk);
        do_job(4'hF, 0, 2, 1'b0, 0, 0, gg);
        chk("post_reset_first_slot", 64'(gg), 64'd0);

        // Randomized jobs against the reference model.
        for (int n = 0; n < 30; n++) begin
            load_desc(1'b1);
            pre = int'($urandom_range(0, 1));
            dat = (pre != 0) ? int'($urandom_range(3, 20)) : int'($urandom_range(1, 20));
            do_job(NS'($urandom_range(1, 15)), int'($urandom_range(0, 3)), dat, pre[0],
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20)),
                   int'($urandom_range(0, 3)), gg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
